// File: rtl/press_classifier_pkg.sv
// Shared types for the press classifier: FSM state encoding and a helper
// that says which states count as "button held".
package press_classifier_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    // A press is in progress in any of the pressed states.
    function automatic logic is_held(input state_t s);
        return (s == PRESS1) || (s == PRESS2) || (s == LONG);
    endfunction

endpackage

// File: rtl/press_classifier_timer.sv
// press_timer: clearable up-counter that saturates at TERM and flags when it
// sits at TERM. The clear input has priority over counting, so a count of 0
// is visible in the cycle after the clear.
module press_timer #(
    parameter int CNT_W = 8,
    parameter int TERM  = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic term
);

    localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

    logic [CNT_W-1:0] count_reg;

    // Count up until TERM, then hold; reset or clr return to zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (count_reg != TERM_V) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign term = (count_reg == TERM_V);

endmodule

// File: rtl/press_classifier.sv
// press_classifier: groups the debounced repeating press pulses into
// presses and classifies each gesture as single click, double click or long
// press. Strobe outputs are registered; held_o decodes the state register.
// Optional macro PRESS_REPEAT_EN adds an auto-repeat strobe while in LONG;
// without it repeat_o is a constant 0.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int GAP_CYCLES  = 16,
    parameter int LONG_PULSES = 8,
    parameter int DBL_WINDOW  = 64,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic press_pulse,
    output logic single_o,
    output logic double_o,
    output logic long_o,
    output logic held_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_PULSES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] pulse_cnt_reg, pulse_cnt_next;
    logic [CNT_W-1:0] pulse_inc;
    logic             single_reg, single_next;
    logic             double_reg, double_next;
    logic             long_reg, long_next;

    logic gap_term, win_term;
    logic release_c, expiry_c, enter_wait2;

    // Gap timer: any pulse clears it, so a pulse always beats a release.
    press_timer #(
        .CNT_W (CNT_W),
        .TERM  (GAP_CYCLES - 1)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (press_pulse),
        .term  (gap_term)
    );

    // Window timer: restarts when the first press of a gesture is released.
    press_timer #(
        .CNT_W (CNT_W),
        .TERM  (DBL_WINDOW - 1)
    ) u_win_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_wait2),
        .term  (win_term)
    );

    assign release_c   = !press_pulse && gap_term;
    assign expiry_c    = !press_pulse && win_term;
    assign enter_wait2 = (state_reg == PRESS1) && release_c;
    assign pulse_inc   = (pulse_cnt_reg == LONG_V) ? pulse_cnt_reg
                                                   : pulse_cnt_reg + 1'b1;

    // State, pulse counter and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pulse_cnt_reg <= '0;
            single_reg    <= 1'b0;
            double_reg    <= 1'b0;
            long_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pulse_cnt_reg <= pulse_cnt_next;
            single_reg    <= single_next;
            double_reg    <= double_next;
            long_reg      <= long_next;
        end
    end

    // Next-state and pulse-count decision.
    always_comb begin
        state_next     = state_reg;
        pulse_cnt_next = pulse_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (press_pulse) begin
                    state_next     = PRESS1;
                    pulse_cnt_next = CNT_W'(1);
                end
            end
            PRESS1, PRESS2: begin
                if (press_pulse) begin
                    pulse_cnt_next = pulse_inc;
                    if (pulse_inc == LONG_V) begin
                        state_next = LONG;
                    end
                end else if (release_c) begin
                    state_next = (state_reg == PRESS1) ? WAIT2 : IDLE;
                end
            end
            WAIT2: begin
                if (press_pulse) begin
                    state_next     = PRESS2;
                    pulse_cnt_next = CNT_W'(1);
                end else if (expiry_c) begin
                    state_next = IDLE;
                end
            end
            LONG: begin
                if (release_c) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                pulse_cnt_next = '0;
            end
        endcase
    end

    // Strobe decisions, registered one cycle later.
    always_comb begin
        single_next = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        case (state_reg)
            PRESS1: begin
                if (press_pulse && (pulse_inc == LONG_V)) begin
                    long_next = 1'b1;
                end
            end
            WAIT2: begin
                if (expiry_c) begin
                    single_next = 1'b1;
                end
            end
            PRESS2: begin
                if (press_pulse && (pulse_inc == LONG_V)) begin
                    single_next = 1'b1;
                    long_next   = 1'b1;
                end else if (release_c) begin
                    double_next = 1'b1;
                end
            end
            default: begin
                single_next = 1'b0;
            end
        endcase
    end

    assign single_o = single_reg;
    assign double_o = double_reg;
    assign long_o   = long_reg;
    assign held_o   = is_held(state_reg);

`ifdef PRESS_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             repeat_reg, repeat_next;

    // Count pulses inside LONG; every LONG_PULSES of them fires a repeat.
    always_comb begin
        rep_cnt_next = rep_cnt_reg;
        repeat_next  = 1'b0;
        if (state_reg != LONG) begin
            rep_cnt_next = '0;
        end else if (press_pulse) begin
            if (rep_cnt_reg + 1'b1 == LONG_V) begin
                rep_cnt_next = '0;
                repeat_next  = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt_reg + 1'b1;
            end
        end
    end

    // Repeat counter and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_reg <= '0;
            repeat_reg  <= 1'b0;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
            repeat_reg  <= repeat_next;
        end
    end

    assign repeat_o = repeat_reg;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: stimulus pushes the expected strobe
// cycle and pattern; a negedge monitor pops and compares whenever a strobe
// appears and flags expected strobes that never arrived.
module tb_press_classifier;

    logic clk = 1'b0;
    logic reset;
    logic press_pulse;
    logic single_o, double_o, long_o, held_o, repeat_o;

    typedef struct {
        int         cyc;
        logic [3:0] v;   // {single, double, long, repeat}
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_t = 0;

    press_classifier #(
        .GAP_CYCLES  (16),
        .LONG_PULSES (8),
        .DBL_WINDOW  (64),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .press_pulse (press_pulse),
        .single_o    (single_o),
        .double_o    (double_o),
        .long_o      (long_o),
        .held_o      (held_o),
        .repeat_o    (repeat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every strobe against the scoreboard head.
    always @(negedge clk) begin
        logic [3:0] got;
        exp_t       e;
        got = {single_o, double_o, long_o, repeat_o};
        if (got != 4'b0000) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe cyc=%0d got=%b required=none", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v != got) begin
                    fails++;
                    $display("FAIL strobe cyc=%0d got=%b required cyc=%0d pattern=%b",
                             cyc, got, e.cyc, e.v);
                end
            end
        end
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_strobe cyc=%0d got=none required cyc=%0d pattern=%b",
                     cyc, e.cyc, e.v);
        end
    end

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
        $display("[TB] expect strobe %b at cycle %0d", v, c);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
        end else begin
            $display("[TB] %s ok cyc=%0d value=%b", name, cyc, got);
        end
    endtask

    task automatic tick(input logic p);
        if (p) last_t = cyc;
        press_pulse = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic pulses(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            if (i < n - 1) idle(spacing - 1);
        end
    endtask

    function automatic logic [4:0] outs();
        return {single_o, double_o, long_o, held_o, repeat_o};
    endfunction

    initial begin
        reset       = 1'b1;
        press_pulse = 1'b0;
        idle(3);
        check("reset_outputs", outs(), 5'b00000);
        reset = 1'b0;
        idle(5);

        // Single click: 3 pulses spaced 12, single_o at t+81.
        pulses(3, 12);
        push(last_t + 81, 4'b1000);
        idle(15);
        check("single_held_before_release", {4'b0000, held_o}, 5'b00001);
        idle(1);
        check("single_held_after_release", {4'b0000, held_o}, 5'b00000);
        idle(90);

        // Double click: second press 30 cycles after release.
        pulses(2, 12);
        idle(16 + 30);
        pulses(2, 12);
        push(last_t + 17, 4'b0100);
        idle(100);

        // Long press: 8 pulses, long_o at t+1, then quiet release.
        pulses(8, 12);
        push(last_t + 1, 4'b0010);
        idle(5);
        check("long_held", {4'b0000, held_o}, 5'b00001);
        idle(30);
        check("long_released", outs(), 5'b00000);
        idle(100);

        // Short click then long press: single and long together.
        tick(1'b1);
        idle(20);
        pulses(8, 12);
        push(last_t + 1, 4'b1010);
        idle(120);

        // Held for 24 pulses: long at 8th, repeats at 16th and 24th if enabled.
        for (int i = 1; i <= 24; i++) begin
            tick(1'b1);
            if (i == 8) push(last_t + 1, 4'b0010);
`ifdef PRESS_REPEAT_EN
            if (i == 16 || i == 24) push(last_t + 1, 4'b0001);
`endif
            idle(11);
        end
        idle(30);
        check("repeat_hold_released", outs(), 5'b00000);
        idle(100);

        // Reset while in WAIT2: gesture is discarded.
        tick(1'b1);
        idle(20);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("midreset_outputs", outs(), 5'b00000);
        idle(120);

        // Fresh click after reset classifies normally.
        tick(1'b1);
        push(last_t + 81, 4'b1000);
        idle(120);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
